// File: rtl/vmem_pkg.sv
// Shared definitions for the vector-load path into the CPU data memory.
// Holds the lane count, the dmem depth, the sequencer state encoding and
// the address range check used by the address generator.
package vmem_pkg;

    localparam int LANES      = 4;
    localparam int DMEM_DEPTH = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } vls_state_t;

    // A word address is usable only if it falls inside the 1024-word dmem.
    function automatic logic dmem_in_range(input logic [31:0] addr);
        return (addr < 32'(DMEM_DEPTH));
    endfunction

endpackage

// File: rtl/vload_agu.sv
// Address generator for the vector-load sequencer.
// Keeps a registered lane-0 address that advances by 4*stride per beat and
// derives lanes 1..3 by adding 1/2/3 x stride, so the dmem addresses depend
// only on registered state.
// Ports:
//   clk, rst      clock, async active-high reset
//   load          command accepted: latch base and stride
//   base, stride  command operands
//   issue         sequencer is in ISSUE (advance after this beat)
//   beat          current beat number
//   len_eff       latched effective element count
//   addr          per-lane dmem address (0 when inactive or out of range)
//   act           lane serves an element below len_eff
//   inr           lane address lies inside dmem
module vload_agu
    import vmem_pkg::*;
#(
    parameter int DW = 32,
    parameter int BW = 3,
    parameter int LW = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [DW-1:0]                base,
    input  logic [DW-1:0]                stride,
    input  logic                         issue,
    input  logic [BW-1:0]                beat,
    input  logic [LW-1:0]                len_eff,
    output logic [LANES-1:0][DW-1:0]     addr,
    output logic [LANES-1:0]             act,
    output logic [LANES-1:0]             inr
);

    logic [DW-1:0] acc;
    logic [DW-1:0] stride_r;
    logic [DW-1:0] raw [LANES];

    // Lane-0 address accumulator and latched stride.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            stride_r <= '0;
        end else if (load) begin
            acc      <= base;
            stride_r <= stride;
        end else if (issue) begin
            acc <= acc + (stride_r << 2);
        end
    end

    // Per-lane address, activity and range masks for the current beat.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            raw[i]  = acc + (stride_r * DW'(i));
            act[i]  = issue && ((32'(beat) * 32'(LANES) + 32'(i)) < 32'(len_eff));
            inr[i]  = dmem_in_range(32'(raw[i]));
            if (act[i] && inr[i]) begin
                addr[i] = raw[i];
            end else begin
                addr[i] = '0;
            end
        end
    end

endmodule

// File: rtl/vload_seq.sv
// Vector-load sequencer: gathers a strided vector of up to VLEN_MAX words
// from the four combinational dmem read ports into a flat result register.
// Ports:
//   clk, rst             clock, async active-high reset
//   start                command strobe (taken only in IDLE)
//   base, stride, len    command: element-0 address, word stride, count
//   addr1..addr4         dmem read addresses, lanes 0..3
//   rdata1..rdata4       dmem read data, same cycle as address
//   vdata                result, element k at [k*DW +: DW]
//   busy                 high while issuing beats
//   done                 one-cycle completion pulse
//   err                  sticky fault (len too big or out-of-range address)
module vload_seq
    import vmem_pkg::*;
#(
    parameter int VLEN_MAX = 16,
    parameter int DW       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [DW-1:0]              base,
    input  logic [DW-1:0]              stride,
    input  logic [$clog2(VLEN_MAX):0]  len,
    output logic [DW-1:0]              addr1,
    output logic [DW-1:0]              addr2,
    output logic [DW-1:0]              addr3,
    output logic [DW-1:0]              addr4,
    input  logic [DW-1:0]              rdata1,
    input  logic [DW-1:0]              rdata2,
    input  logic [DW-1:0]              rdata3,
    input  logic [DW-1:0]              rdata4,
    output logic [VLEN_MAX*DW-1:0]     vdata,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int LW = $clog2(VLEN_MAX) + 1;
    localparam int BW = $clog2(VLEN_MAX / LANES) + 1;
    localparam int EW = $clog2(VLEN_MAX);

    vls_state_t                 state;
    logic [BW-1:0]              beat;
    logic [LW-1:0]              len_r;
    logic [LW-1:0]              len_eff;
    logic                       len_big;
    logic                       accept;
    logic                       issue;
    logic                       last_beat;
    logic [DW-1:0]              elem [VLEN_MAX];
    logic [LANES-1:0][DW-1:0]   lane_addr;
    logic [LANES-1:0][DW-1:0]   rd;
    logic [LANES-1:0]           act;
    logic [LANES-1:0]           inr;

    assign accept = (state == IDLE) && start;
    assign issue  = (state == ISSUE);
    assign rd     = {rdata4, rdata3, rdata2, rdata1};
    assign addr1  = lane_addr[0];
    assign addr2  = lane_addr[1];
    assign addr3  = lane_addr[2];
    assign addr4  = lane_addr[3];

    for (genvar k = 0; k < VLEN_MAX; k++) begin : g_flat
        assign vdata[k*DW +: DW] = elem[k];
    end

    // Length clamp and last-beat detection.
    always_comb begin
        len_big   = (len > LW'(VLEN_MAX));
        len_eff   = len;
        if (len_big) begin
            len_eff = LW'(VLEN_MAX);
        end else begin
            len_eff = len;
        end
        last_beat = ((32'(beat) + 32'd1) * 32'(LANES)) >= 32'(len_r);
    end

    vload_agu #(
        .DW (DW),
        .BW (BW),
        .LW (LW)
    ) u_agu (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .base    (base),
        .stride  (stride),
        .issue   (issue),
        .beat    (beat),
        .len_eff (len_r),
        .addr    (lane_addr),
        .act     (act),
        .inr     (inr)
    );

    // Sequencer FSM with registered status outputs and element capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
            len_r <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            for (int k = 0; k < VLEN_MAX; k++) begin
                elem[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_r <= len_eff;
                        beat  <= '0;
                        err   <= len_big;
                        for (int k = 0; k < VLEN_MAX; k++) begin
                            elem[k] <= '0;
                        end
                        if (len_eff == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // Out-of-range lanes store zero and flag the fault.
                    for (int i = 0; i < LANES; i++) begin
                        if (act[i]) begin
                            elem[EW'(32'(beat) * 32'(LANES) + 32'(i))] <= inr[i] ? rd[i] : '0;
                            if (!inr[i]) begin
                                err <= 1'b1;
                            end
                        end
                    end
                    beat <= beat + BW'(1);
                    if (last_beat) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
